// File: rtl/rf_mp_sb_if.sv
// Register-file bus: decode-side reads/alloc, writeback-side writes and the
// clear-sweep handshake. The master drives requests, the slave is the register file.
interface rf_mp_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1
) ();
    localparam int AW = $clog2(NREG);

    logic                 clr_req;
    logic                 ready;
    logic [NWR-1:0]       we;
    logic [NWR*AW-1:0]    waddr;
    logic [NWR*XLEN-1:0]  wdata;
    logic                 alloc_en;
    logic [AW-1:0]        alloc_rd;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*XLEN-1:0]  rdata;
    logic [NRD-1:0]       rbusy;

    modport master (
        output clr_req, we, waddr, wdata, alloc_en, alloc_rd, raddr,
        input  ready, rdata, rbusy
    );

    modport slave (
        input  clr_req, we, waddr, wdata, alloc_en, alloc_rd, raddr,
        output ready, rdata, rbusy
    );
endinterface

// File: rtl/rf_mp_sb.sv
// Multi-port integer register file with busy-bit scoreboard and a clear
// sequencer that zeroes x1..x(NREG-1), one register per cycle.
// x0 is hardwired to zero and never busy.
module rf_mp_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rstn,
    rf_mp_sb_if.slave    bus
);
    localparam int AW = $clog2(NREG);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;

    // Per-port views of the packed write/read buses.
    logic [AW-1:0]   waddr_w [NWR];
    logic [XLEN-1:0] wdata_w [NWR];
    logic [AW-1:0]   raddr_r [NRD];

    logic [NRD*XLEN-1:0] rdata_c;
    logic [NRD-1:0]      rbusy_c;

    for (genvar k = 0; k < NWR; k++) begin : g_wport
        assign waddr_w[k] = bus.waddr[k*AW +: AW];
        assign wdata_w[k] = bus.wdata[k*XLEN +: XLEN];
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rport
        assign raddr_r[i] = bus.raddr[i*AW +: AW];
    end

    // Read ports: storage lookup, optionally overridden by a same-cycle write.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        rdata_c = '0;
        rbusy_c = '0;
        for (int i = 0; i < NRD; i++) begin
            if (raddr_r[i] != '0) begin
                rdata_c[i*XLEN +: XLEN] = regs_q[raddr_r[i]];
                rbusy_c[i]              = busy_q[raddr_r[i]];
                if (BYPASS != 0 && state_q == ST_RUN) begin
                    // Ascending scan: the highest matching port is applied last.
                    for (int k = 0; k < NWR; k++) begin
                        if (bus.we[k] && waddr_w[k] == raddr_r[i]) begin
                            rdata_c[i*XLEN +: XLEN] = wdata_w[k];
                            rbusy_c[i]              = 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign bus.rdata = rdata_c;
    assign bus.rbusy = rbusy_c;
    assign bus.ready = (state_q == ST_RUN);

    // Next-state: writes, scoreboard updates and the clear sweep.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        regs_d  = regs_q;
        busy_d  = busy_q;

        unique case (state_q)
            ST_RUN: begin
                // Ascending scan so the highest-index port wins on a collision.
                for (int k = 0; k < NWR; k++) begin
                    if (bus.we[k] && waddr_w[k] != '0) begin
                        regs_d[waddr_w[k]] = wdata_w[k];
                        busy_d[waddr_w[k]] = 1'b0;
                    end
                end
                // Alloc after writes: a new producer issued in the same cycle
                // as the old one retires leaves the register busy.
                if (bus.alloc_en && bus.alloc_rd != '0) begin
                    busy_d[bus.alloc_rd] = 1'b1;
                end
                if (bus.clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = AW'(1);
                    busy_d  = '0;
                end
            end

            ST_CLEAR: begin
                regs_d[ptr_q] = '0;
                if (ptr_q == AW'(NREG - 1)) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end

            default: begin
                state_d = ST_RUN;
                ptr_d   = '0;
            end
        endcase
    end

    // State register, sweep pointer, scoreboard and register storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            busy_q  <= '0;
            // NOTE: the storage array is reset because architectural state must
            // read zero after reset; this costs a reset on every bit.
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            regs_q  <= regs_d;
        end
    end
endmodule
